// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional AES_ENC_LASTKEY_EN: register the round-10 key on key_last for the decrypt path.
module aes_enc_iter #(
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic [127:0] key_last
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(10);

    // Forward S-box, byte 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    fsm_t             state, state_next;
    logic [127:0]     state_reg, rk_reg, rk_next, sb, sr, mc, round_out;
    logic [CNT_W-1:0] rnd;
    logic [7:0]       rcon;
    logic [31:0]      w0, w1, w2, w3, t;
    logic             accept, last;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (rnd == LAST_RND);

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            CNT_W'(1):  rcon = 8'h01;
            CNT_W'(2):  rcon = 8'h02;
            CNT_W'(3):  rcon = 8'h04;
            CNT_W'(4):  rcon = 8'h08;
            CNT_W'(5):  rcon = 8'h10;
            CNT_W'(6):  rcon = 8'h20;
            CNT_W'(7):  rcon = 8'h40;
            CNT_W'(8):  rcon = 8'h80;
            CNT_W'(9):  rcon = 8'h1b;
            CNT_W'(10): rcon = 8'h36;
            default:    rcon = 8'h00;
        endcase
    end

    // Next round key; RotWord folded into the S-box byte order.
    always_comb begin
        {w0, w1, w2, w3} = rk_reg;
        t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        rk_next[127:96] = w0 ^ t;
        rk_next[95:64]  = w1 ^ rk_next[127:96];
        rk_next[63:32]  = w2 ^ rk_next[95:64];
        rk_next[31:0]   = w3 ^ rk_next[63:32];
    end

    // Byte index 4*col+row; ShiftRows pulls row r from column (c+r)%4.
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++)
            sb[127-8*i -: 8] = sbox(state_reg[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    assign round_out = (last ? sr : mc) ^ rk_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ROUND;
            ROUND:   if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = in_valid ? ROUND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            rk_reg    <= '0;
            rnd       <= '0;
            ct_out    <= '0;
        end else if (accept) begin
            state_reg <= pt_in ^ key_in;
            rk_reg    <= key_in;
            rnd       <= CNT_W'(1);
        end else if (state == ROUND) begin
            state_reg <= round_out;
            rk_reg    <= rk_next;
            rnd       <= last ? '0 : rnd + 1'b1;
            if (last) ct_out <= round_out;
        end
    end

`ifdef AES_ENC_LASTKEY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     key_last <= '0;
        else if (state == ROUND && last) key_last <= rk_next;
    end
`else
    assign key_last = '0;
`endif

endmodule
